relogio_duplo: RTL and testbench

Two-player countdown chess clock. Each player's remaining time is loaded with a preset and counts down on the global tick enable while it is that player's turn. A move hands the turn over and credits a bonus. A penalty pulse deducts a fixed amount from the player on turn. The block sits next to the game FSM: it consumes the move, penalty and pause strobes and returns remaining times plus a flag-fall indication to the display and game-end logic.

---
 rtl/relogio_duplo.sv | 169 ++++++++++++++++
 tb/tb_relogio_duplo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/relogio_duplo.sv
// ---------------------------------------------------------------------------
// relogio_duplo -- two-player countdown chess clock.
//
// Each player's remaining time loads T0 on start and counts down on `tick`
// while it is that player's turn. A move (`jogada`) hands the turn over.
// A penalty deducts PEN from the player on turn. `pausa` freezes the clock.
// When the on-turn time reaches zero, that player's flag falls and the clock
// stops until the next `inicia`.
//
// Optional feature macro: RELOGIO_INCREMENTO_EN
//   defined   -> Fischer mode: each move credits INC to the mover, saturating
//                at TMAX.
//   undefined -> a move only toggles the turn, and INC is unused.
//
// Parameters:
//   T0    initial time per player (ticks)
//   INC   per-move bonus (ticks), Fischer mode only
//   PEN   penalty amount (ticks)
//   TMAX  saturation ceiling, T0 <= TMAX < 2**N
//   N     width of the time registers
//
// Ports:
//   clock     single clock, rising edge
//   zera_n    synchronous active-low reset
//   inicia    start/restart pulse (honoured only when idle or flagged)
//   tick      time-base enable, one unit of time per asserted cycle
//   jogada    pulse: on-turn player completed a move
//   penaliza  pulse: deduct PEN from the on-turn player
//   pausa     level: hold the clock while high
//   tempo_b   white's remaining time
//   tempo_p   black's remaining time
//   vez       player on turn (0 = white, 1 = black)
//   rodando   high while counting
//   fim_b     white's flag fell
//   fim_p     black's flag fell
//   fim       either flag fell
// ---------------------------------------------------------------------------
module relogio_duplo #(
  parameter int T0   = 300000,
  parameter int INC  = 2000,
  parameter int PEN  = 1000,
  parameter int TMAX = 600000,
  parameter int N    = 20
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         inicia,
  input  logic         tick,
  input  logic         jogada,
  input  logic         penaliza,
  input  logic         pausa,
  output logic [N-1:0] tempo_b,
  output logic [N-1:0] tempo_p,
  output logic         vez,
  output logic         rodando,
  output logic         fim_b,
  output logic         fim_p,
  output logic         fim
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CONTA  = 2'd1,
    PAUSA  = 2'd2,
    FIM    = 2'd3
  } estado_t;

  localparam logic [N-1:0] T0_N  = N'(T0);
  localparam logic [N:0]   PEN_W = (N+1)'(PEN);

  estado_t      estado;
  logic [N-1:0] t_vez;     // on-turn time
  logic [N:0]   t_ext;     // on-turn time widened for the no-wrap subtraction
  logic [N:0]   deducao;   // tick + optional penalty
  logic [N-1:0] t1;        // on-turn time after deduction, floored at zero
  logic [N-1:0] t_move;    // on-turn time when a move is made

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    t_vez   = vez ? tempo_p : tempo_b;
    t_ext   = {1'b0, t_vez};
    deducao = (N+1)'(tick) + (penaliza ? PEN_W : '0);
    t1      = '0;
    // Only take the difference when it is positive; otherwise floor at zero.
    if (t_ext > deducao) t1 = N'(t_ext - deducao);
  end

`ifdef RELOGIO_INCREMENTO_EN
  localparam logic [N+1:0] INC_W  = (N+2)'(INC);
  localparam logic [N+1:0] TMAX_W = (N+2)'(TMAX);

  logic [N+1:0] soma;

  // Bonus added in N+2 bits so the sum cannot wrap before the ceiling clamp.
  always_comb begin
    soma   = (N+2)'(t1) + INC_W;
    t_move = (soma > TMAX_W) ? N'(TMAX_W) : N'(soma);
  end
`else
  assign t_move = t1;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every update sees the values from before this edge.
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      estado  <= OCIOSO;
      tempo_b <= T0_N;
      tempo_p <= T0_N;
      vez     <= 1'b0;
      rodando <= 1'b0;
      fim_b   <= 1'b0;
      fim_p   <= 1'b0;
      fim     <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          if (inicia) begin
            estado  <= CONTA;
            tempo_b <= T0_N;
            tempo_p <= T0_N;
            vez     <= 1'b0;
            rodando <= 1'b1;
            fim_b   <= 1'b0;
            fim_p   <= 1'b0;
            fim     <= 1'b0;
          end
        end

        CONTA: begin
          if (pausa) begin
            estado  <= PAUSA;
            rodando <= 1'b0;
          end else if (t1 == '0) begin
            // Flag fall wins over a simultaneous move: turn is held.
            estado  <= FIM;
            rodando <= 1'b0;
            fim     <= 1'b1;
            if (vez) begin
              tempo_p <= '0;
              fim_p   <= 1'b1;
            end else begin
              tempo_b <= '0;
              fim_b   <= 1'b1;
            end
          end else begin
            if (vez) tempo_p <= jogada ? t_move : t1;
            else     tempo_b <= jogada ? t_move : t1;
            if (jogada) vez <= ~vez;
          end
        end

        PAUSA: begin
          if (!pausa) begin
            estado  <= CONTA;
            rodando <= 1'b1;
          end
        end

        default: begin
          estado  <= OCIOSO;
          rodando <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relogio_duplo.sv
// ---------------------------------------------------------------------------
// tb_relogio_duplo -- directed, self-checking bench for relogio_duplo with
// T0=10, INC=3, PEN=4, TMAX=15, N=5. Expected values are hand-computed; the
// move bonus B is 3 when RELOGIO_INCREMENTO_EN is defined and 0 otherwise.
// ---------------------------------------------------------------------------
module tb_relogio_duplo;

`ifdef RELOGIO_INCREMENTO_EN
  localparam int B = 3;
  // Ceiling walk: white 10->13, black 10->13, white 13->15 (clamped),
  // black 13->15, white tick 15->14, white move 14->15 (clamped).
  localparam int C_W1 = 13, C_W2 = 15, C_W3 = 14, C_W4 = 15;
`else
  localparam int B = 0;
  // Without the bonus the moves leave the times alone: only the tick counts.
  localparam int C_W1 = 10, C_W2 = 10, C_W3 = 9, C_W4 = 9;
`endif

  logic       clock = 1'b0;
  logic       zera_n, inicia, tick, jogada, penaliza, pausa;
  logic [4:0] tempo_b, tempo_p;
  logic       vez, rodando, fim_b, fim_p, fim;

  int n_checks = 0;
  int n_fail   = 0;

  relogio_duplo #(
    .T0(10), .INC(3), .PEN(4), .TMAX(15), .N(5)
  ) dut (
    .clock   (clock),
    .zera_n  (zera_n),
    .inicia  (inicia),
    .tick    (tick),
    .jogada  (jogada),
    .penaliza(penaliza),
    .pausa   (pausa),
    .tempo_b (tempo_b),
    .tempo_p (tempo_p),
    .vez     (vez),
    .rodando (rodando),
    .fim_b   (fim_b),
    .fim_p   (fim_p),
    .fim     (fim)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Let n rising edges sample the current inputs, then settle past the edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic restart();
    inicia = 1'b1;
    step();
    inicia = 1'b0;
  endtask

  initial begin
    zera_n = 1'b0; inicia = 1'b0; tick = 1'b0;
    jogada = 1'b0; penaliza = 1'b0; pausa = 1'b0;

    // Reset state
    step();
    check("rst_tempo_b", tempo_b, 10);
    check("rst_tempo_p", tempo_p, 10);
    check("rst_vez", vez, 0);
    check("rst_rodando", rodando, 0);
    check("rst_fim", fim, 0);

    // Start, four ticks, move
    zera_n = 1'b1;
    restart();
    check("start_rodando", rodando, 1);
    check("start_tempo_b", tempo_b, 10);
    tick = 1'b1;
    step(4);
    tick = 1'b0;
    check("tick4_tempo_b", tempo_b, 6);
    jogada = 1'b1;
    step();
    jogada = 1'b0;
    check("move_tempo_b", tempo_b, 6 + B);
    check("move_vez", vez, 1);
    tick = 1'b1;
    step(2);
    tick = 1'b0;
    check("black_tick_tempo_p", tempo_p, 8);
    check("black_tick_tempo_b", tempo_b, 6 + B);

    // Pause for 5 cycles with every other input active
    pausa = 1'b1; tick = 1'b1; jogada = 1'b1; penaliza = 1'b1; inicia = 1'b1;
    step();
    check("pause_rodando", rodando, 0);
    check("pause_entry_tempo_p", tempo_p, 8);
    step(4);
    pausa = 1'b0; tick = 1'b0; jogada = 1'b0; penaliza = 1'b0; inicia = 1'b0;
    check("pause_tempo_p", tempo_p, 8);
    check("pause_tempo_b", tempo_b, 6 + B);
    check("pause_vez", vez, 1);
    step();
    check("resume_rodando", rodando, 1);

    // Black moves, white ticks down to 1
    jogada = 1'b1;
    step();
    jogada = 1'b0;
    check("black_move_tempo_p", tempo_p, 8 + B);
    check("black_move_vez", vez, 0);
    tick = 1'b1;
    step(5 + B);
    check("white_at1", tempo_b, 1);

    // Flag beats move
    jogada = 1'b1;
    step();
    jogada = 1'b0; tick = 1'b0;
    check("flag_tempo_b", tempo_b, 0);
    check("flag_fim_b", fim_b, 1);
    check("flag_fim_p", fim_p, 0);
    check("flag_fim", fim, 1);
    check("flag_vez", vez, 0);
    check("flag_rodando", rodando, 0);
    check("flag_tempo_p", tempo_p, 8 + B);

    // Inputs other than inicia are ignored in FIM
    tick = 1'b1; penaliza = 1'b1; jogada = 1'b1;
    step();
    tick = 1'b0; penaliza = 1'b0; jogada = 1'b0;
    check("fim_hold_tempo_p", tempo_p, 8 + B);
    check("fim_hold_fim", fim, 1);

    // Restart from FIM; the tick alongside inicia is ignored
    inicia = 1'b1; tick = 1'b1;
    step();
    inicia = 1'b0; tick = 1'b0;
    check("restart_tempo_b", tempo_b, 10);
    check("restart_tempo_p", tempo_p, 10);
    check("restart_fim", fim, 0);
    check("restart_fim_b", fim_b, 0);
    check("restart_rodando", rodando, 1);

    // Penalty saturation: white at 3, tick + penalty deducts 5
    tick = 1'b1;
    step(7);
    check("white_at3", tempo_b, 3);
    penaliza = 1'b1;
    step();
    penaliza = 1'b0; tick = 1'b0;
    check("pen_sat_tempo_b", tempo_b, 0);
    check("pen_sat_fim_b", fim_b, 1);
    check("pen_sat_fim", fim, 1);
    check("pen_sat_rodando", rodando, 0);

    // One tick then a move from 10
    restart();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("one_tick_tempo_b", tempo_b, 9);
    jogada = 1'b1;
    step();
    jogada = 1'b0;
    check("one_move_tempo_b", tempo_b, 9 + B);
    check("one_move_vez", vez, 1);

    // Black penalties alone: 10 -> 6 -> 2 -> flag
    penaliza = 1'b1;
    step();
    check("pen1_tempo_p", tempo_p, 6);
    step();
    check("pen2_tempo_p", tempo_p, 2);
    step();
    penaliza = 1'b0;
    check("pen3_tempo_p", tempo_p, 0);
    check("pen3_fim_p", fim_p, 1);
    check("pen3_fim_b", fim_b, 0);
    check("pen3_fim", fim, 1);
    check("pen3_vez", vez, 1);
    check("pen3_tempo_b", tempo_b, 9 + B);

    // Ceiling walk
    restart();
    jogada = 1'b1;
    step();
    check("ceil_w1", tempo_b, C_W1);
    step();
    check("ceil_b1", tempo_p, C_W1);
    step();
    check("ceil_w2", tempo_b, C_W2);
    step();
    check("ceil_b2", tempo_p, C_W2);
    jogada = 1'b0; tick = 1'b1;
    step();
    check("ceil_w_tick", tempo_b, C_W3);
    tick = 1'b0; jogada = 1'b1;
    step();
    jogada = 1'b0;
    check("ceil_w3", tempo_b, C_W4);
    check("ceil_vez", vez, 1);

    // Mid-game reset overrides every other input
    zera_n = 1'b0; inicia = 1'b1; jogada = 1'b1; tick = 1'b1;
    step();
    check("midrst_tempo_b", tempo_b, 10);
    check("midrst_tempo_p", tempo_p, 10);
    check("midrst_vez", vez, 0);
    check("midrst_rodando", rodando, 0);
    check("midrst_fim", fim, 0);

    // Idle ignores tick and moves
    zera_n = 1'b1; inicia = 1'b0;
    step(2);
    jogada = 1'b0; tick = 1'b0;
    check("idle_tempo_b", tempo_b, 10);
    check("idle_vez", vez, 0);
    check("idle_rodando", rodando, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
